// File: rtl/instr_prefetch_buffer_if.sv
// Instruction prefetch buffer bus bundle.
//   mem_req / mem_addr           : read request to instruction memory
//   mem_ack / mem_rdata          : request accepted, returned word valid
//   redirect / redirect_pc       : taken branch from decode, new fetch address
//   instr_valid / instr /
//   instr_pc_plus_4              : queue head presented to decode
//   instr_ready                  : decode accepts the head this cycle
// Modports: master = prefetch buffer side, slave = memory/decode side.
interface instr_prefetch_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc_plus_4;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc_plus_4,
    input  mem_ack, mem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc_plus_4,
    output mem_ack, mem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: fetches sequential instruction words from
// memory (one outstanding request at a time) into a DEPTH-entry queue and
// presents the head to decode. A redirect flushes the queue, restarts fetch
// at redirect_pc and drops the word of any request still in flight.
//
// Parameters: DEPTH (queue entries, power of two 2..16), RESET_PC.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - instr_prefetch_buffer_if.master (memory request/response,
//          redirect, decode handshake)
// Optional feature: define PREFETCH_BYPASS_EN to forward mem_rdata straight
// to decode in the ack cycle when the queue is empty; otherwise the path
// from memory to decode is registered (1-cycle latency).
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                     CLK,
  input logic                     RST,
  instr_prefetch_buffer_if.master bus
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;   // next address to request
  logic [31:0]   req_addr;   // address of the request on the bus
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc4   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          q_empty;
  logic          issue, accept, push, pop;
  logic [31:0]   ack_pc4;
`ifdef PREFETCH_BYPASS_EN
  logic          bypass_hit;
`endif

  assign q_empty = (count == '0);
  assign ack_pc4 = req_addr + 32'd4;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. A request is only launched from IDLE with no
  // same-cycle redirect, so it always uses the already-updated fetch_pc.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!bus.redirect && (count < DEPTH_C)) state_nxt = REQ;
      REQ:     if (bus.mem_ack)       state_nxt = IDLE;
               else if (bus.redirect) state_nxt = DRAIN;
      DRAIN:   if (bus.mem_ack)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    bus.mem_req  = (state != IDLE);
    bus.mem_addr = req_addr;
    issue        = (state == IDLE) && (state_nxt == REQ);
    // Ack of a live (not draining, not overridden) request
    accept       = (state == REQ) && bus.mem_ack && !bus.redirect;
    pop          = !q_empty && bus.instr_ready && !bus.redirect;
`ifdef PREFETCH_BYPASS_EN
    bypass_hit          = q_empty && accept;
    bus.instr_valid     = !q_empty || bypass_hit;
    bus.instr           = bypass_hit ? bus.mem_rdata : q_instr[rd_ptr];
    bus.instr_pc_plus_4 = bypass_hit ? ack_pc4       : q_pc4[rd_ptr];
    // A forwarded word taken by decode in the same cycle never enters the queue
    push                = accept && !(bypass_hit && bus.instr_ready);
`else
    bus.instr_valid     = !q_empty;
    bus.instr           = q_instr[rd_ptr];
    bus.instr_pc_plus_4 = q_pc4[rd_ptr];
    push                = accept;
`endif
  end

  // Fetch pointer, request address and queue storage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc4[i]   <= '0;
      end
    end else begin
      if (issue) req_addr <= fetch_pc;

      if (bus.redirect)  fetch_pc <= bus.redirect_pc;
      else if (accept)   fetch_pc <= ack_pc4;

      if (push) begin
        q_instr[wr_ptr] <= bus.mem_rdata;
        q_pc4[wr_ptr]   <= ack_pc4;
      end

      if (bus.redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_prefetch_buffer_if bus ();

  instr_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: queue of delivered words plus request bookkeeping
  logic [31:0] mq_instr [$];
  logic [31:0] mq_pc4   [$];
  bit          m_out;      // a request is on the bus
  bit          m_disc;     // its word will be dropped
  logic [31:0] m_addr;
  logic [31:0] m_fetch;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F11;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    mq_instr.delete();
    mq_pc4.delete();
    m_out   = 1'b0;
    m_disc  = 1'b0;
    m_addr  = RESET_PC;
    m_fetch = RESET_PC;
  endtask

  // Effect of one clock edge with the given inputs
  task automatic model_step(input bit ack, input bit ready, input bit redir,
                            input logic [31:0] rpc);
    int unsigned sz;
    bit          launch;
    sz     = mq_instr.size();
    launch = !m_out && !redir && (sz < DEPTH);
    if (sz > 0 && ready && !redir) begin
      void'(mq_instr.pop_front());
      void'(mq_pc4.pop_front());
    end
    if (m_out && ack) begin
      if (!m_disc && !redir) begin
        mq_instr.push_back(mem_word(m_addr));
        mq_pc4.push_back(m_addr + 32'd4);
        m_fetch = m_addr + 32'd4;
      end
      m_out  = 1'b0;
      m_disc = 1'b0;
    end else if (m_out && redir) begin
      m_disc = 1'b1;
    end
    if (redir) begin
      mq_instr.delete();
      mq_pc4.delete();
      m_fetch = rpc;
    end
    if (launch) begin
      m_out  = 1'b1;
      m_disc = 1'b0;
      m_addr = m_fetch;
    end
  endtask

  task automatic compare_model();
    check("mem_req", {31'd0, bus.mem_req}, {31'd0, m_out});
    if (m_out) check("mem_addr", bus.mem_addr, m_addr);
    check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, mq_instr.size() > 0});
    if (mq_instr.size() > 0) begin
      check("instr", bus.instr, mq_instr[0]);
      check("instr_pc_plus_4", bus.instr_pc_plus_4, mq_pc4[0]);
    end
  endtask

  task automatic cycle(input bit ack, input bit ready, input bit redir,
                       input logic [31:0] rpc);
    bus.mem_ack     = ack;
    bus.instr_ready = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.mem_rdata   = mem_word(bus.mem_addr);
    model_step(ack, ready, redir, rpc);
    @(posedge clk);
    #2;
    compare_model();
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_mem_req"},     {31'd0, bus.mem_req},     32'd0);
    check({tag, "_mem_addr"},    bus.mem_addr,             RESET_PC);
    check({tag, "_instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    check({tag, "_instr"},       bus.instr,                32'd0);
    check({tag, "_pc4"},         bus.instr_pc_plus_4,      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;

    // Power-on reset with a stale ack
    #3;
    reset_values("rst0");
    bus.mem_ack = 1'b1;
    @(posedge clk); #2;
    reset_values("rst0_ack");
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();

    // Streaming: ack every request, decode always ready
    for (int i = 0; i < 20; i++) cycle(bus.mem_req, 1'b1, 1'b0, 32'h0);

    // Decode stalled: exactly DEPTH words queued, then fetch stops
    cycle(bus.mem_req, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 16; i++) cycle(bus.mem_req, 1'b0, 1'b0, 32'h0);
    check("full_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("full_valid",   {31'd0, bus.instr_valid}, 32'd1);
    check("full_head",    bus.instr, mem_word(32'h0));
    check("full_pc4",     bus.instr_pc_plus_4, 32'h4);

    // Redirect while the request to 0x8 is pending; its ack arrives 3 cycles later
    cycle(1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 40 && !(bus.mem_req && bus.mem_addr == 32'h8); i++)
      cycle(bus.mem_req, 1'b1, 1'b0, 32'h0);
    check("wait_addr8", {31'd0, bus.mem_req && bus.mem_addr == 32'h8}, 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 32'h100);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("drain_done_req", {31'd0, bus.mem_req}, 32'd0);
    check("drain_no_valid", {31'd0, bus.instr_valid}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("redir_addr", bus.mem_addr, 32'h100);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("redir_pc4",   bus.instr_pc_plus_4, 32'h104);

    // Full queue: redirect, pop and a stray ack in the same cycle
    for (int i = 0; i < 16; i++) cycle(bus.mem_req, 1'b0, 1'b0, 32'h0);
    check("full2_req", {31'd0, bus.mem_req}, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h200);
    check("flush_valid", {31'd0, bus.instr_valid}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("flush_addr", bus.mem_addr, 32'h200);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Address wrap at the top of memory
    cycle(bus.mem_req, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 10 && !bus.mem_req; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_pc4", bus.instr_pc_plus_4, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_next_addr", bus.mem_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rpc = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                        : (32'hFFFF_FFF0 | ($urandom & 32'hC));
      cycle(bus.mem_req && ($urandom_range(0, 2) != 0),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0,
            rpc);
    end

    // Reset mid-operation: three entries queued and a request in flight
    cycle(bus.mem_req, 1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 40 && !(mq_instr.size() == 3 && m_out); i++)
      cycle(bus.mem_req && (mq_instr.size() < 3), 1'b0, 1'b0, 32'h0);
    check("wait_occ3", {31'd0, mq_instr.size() == 3 && m_out && bus.mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    reset_values("rst1");
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #2;
    reset_values("rst1_ack");
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("post_rst_addr", bus.mem_addr, RESET_PC);
    check("post_rst_req",  {31'd0, bus.mem_req}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("post_rst_pc4",  bus.instr_pc_plus_4, RESET_PC + 32'd4);
    for (int i = 0; i < 10; i++) cycle(bus.mem_req, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued instruction entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  instruction-memory read request, held until acknowledged.
REQ-006 SHALL have port mem_addr  output  32  byte address of the pending request, word aligned.
REQ-007 SHALL have port mem_ack  input  1  request accepted and mem_rdata valid this cycle.
REQ-008 SHALL have port mem_rdata  input  32  returned instruction word.
REQ-009 SHALL have port redirect  input  1  taken branch from decode; discard queue and restart.
REQ-010 SHALL have port redirect_pc  input  32  new fetch address, valid with redirect.
REQ-011 SHALL have port instr_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port instr  output  32  head instruction word.
REQ-013 SHALL have port instr_pc_plus_4  output  32  head instruction address plus 4.
REQ-014 SHALL have port instr_ready  input  1  decode accepts head this cycle (decode stall deasserted).

Function
REQ-015 SHALL hold at most one outstanding memory request; mem_addr and mem_req SHALL stay stable from assertion until the mem_ack cycle.
REQ-016 SHALL implement FSM states IDLE, REQ, DRAIN: IDLE -> REQ when free slots exceed in-flight requests; REQ -> IDLE on mem_ack; REQ -> DRAIN on redirect without mem_ack; DRAIN -> IDLE on mem_ack.
REQ-017 SHALL assert mem_req in REQ and DRAIN, and deassert it in IDLE.
REQ-018 SHALL push {mem_rdata, mem_addr+4} into the queue on mem_ack in REQ; on mem_ack in DRAIN the word SHALL be discarded.
REQ-019 SHALL advance the fetch pointer by 4 on every accepted push, wrapping modulo 2^32.
REQ-020 SHALL pop the head when instr_valid and instr_ready are both 1; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-021 SHALL never push when full; a request SHALL be issued only if occupancy plus in-flight is less than DEPTH.
REQ-022 SHALL, on redirect, clear the queue, set instr_valid to 0 the next cycle, and load the fetch pointer with redirect_pc; redirect SHALL win over a same-cycle pop or push.
REQ-023 SHALL issue the first request to redirect_pc no earlier than the cycle after any outstanding discarded request is acknowledged.
REQ-024 SHALL give instruction latency of 1 cycle from mem_ack to instr_valid when the queue is empty (registered path).
REQ-025 SHALL present instructions in strict address order with no duplicates or gaps between redirects.

Reset
REQ-026 SHALL, while RST is high, force the state to IDLE, occupancy to 0, mem_req 0, mem_addr RESET_PC, instr_valid 0, instr 0 and instr_pc_plus_4 0.
REQ-027 SHALL discard any request in flight when RST is asserted mid-operation, and issue the first request to RESET_PC on the first clock edge after RST falls.

Configuration
REQ-028 SHALL, with PREFETCH_BYPASS_EN defined, drive instr/instr_pc_plus_4 directly from mem_rdata/mem_addr+4 and assert instr_valid in the same cycle when the queue is empty and mem_ack is in REQ; if instr_ready is 1, the word SHALL be consumed without a push.
REQ-029 SHALL, without PREFETCH_BYPASS_EN, keep the 1-cycle registered latency of REQ-024 and have no combinational path from mem_* to instr_*.

Verification
REQ-030 Reset release, mem_ack every cycle, instr_ready=1 -> mem_addr 0x0,0x4,0x8...; instr_pc_plus_4 0x4,0x8,0xC... in order.
REQ-031 instr_ready=0, mem_ack always 1, DEPTH=4 -> exactly 4 pushes, then mem_req=0 and head stays at the 0x0 instruction.
REQ-032 Redirect to 0x100 while a request to 0x8 is pending, mem_ack 3 cycles later -> the 0x8 word is dropped; next mem_addr=0x100; first instr_pc_plus_4=0x104.
REQ-033 Full queue with redirect, pop, and mem_ack in the same cycle -> queue empty next cycle; fetch resumes at redirect_pc.
REQ-034 Fetch pointer 0xFFFF_FFFC acknowledged -> instr_pc_plus_4=0x0000_0000; next mem_addr=0x0.
REQ-035 RST pulse with occupancy 3 and a request in flight -> all outputs at reset values; first request to RESET_PC; a stale mem_ack during RST is ignored.
